// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch entries pair an instruction word with its PC.
package cpu_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_INSTR_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]  pc;
        logic [DEF_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             a_reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= din;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: in-order imem requests, PC-tagged
// return buffer, decode handshake and redirect flush.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   a_reset_n,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    output logic                   pc_hold,
    input  logic                   redirect,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [INSTR_WIDTH-1:0] dec_instr,
    output logic [ADDR_WIDTH-1:0]  dec_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $bits(fetch_entry_t);

    logic [CW-1:0]         inflight;
    logic [CW-1:0]         drop;
    logic [CW-1:0]         pend_count;
    logic [CW-1:0]         out_count;
    logic                  pend_full;
    logic                  pend_empty;
    logic                  out_full;
    logic                  out_empty;
    logic [ADDR_WIDTH-1:0] pend_pc;
    fetch_entry_t          out_head;
    fetch_entry_t          out_din;
    logic                  pop;
    logic                  credit;
    logic                  issue;
    logic                  rsp_keep;

    assign dec_valid = ~out_empty;
    assign pop       = dec_valid & dec_ready;

    // Buffered words count against the budget until decode takes them.
    always_comb begin
        credit = (int'(inflight) + int'(out_count)
                  - int'(pop)) < DEPTH;
    end

    assign imem_req_valid = a_reset_n & ~redirect & credit;
    assign imem_req_addr  = pc_addr;
    assign issue          = imem_req_valid & imem_req_ready;
    assign pc_hold        = ~issue;

    assign rsp_keep = imem_rsp_valid & ~redirect
                    & (drop == '0);

    assign out_din.pc    = pend_pc;
    assign out_din.instr = imem_rsp_data;

    assign dec_pc    = dec_valid ? out_head.pc    : '0;
    assign dec_instr = dec_valid ? out_head.instr : '0;

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            inflight <= '0;
            drop     <= '0;
        end else begin
            assert (!(imem_rsp_valid && inflight == '0));
            assert (!(issue && pend_full));
            assert (!(rsp_keep && pend_empty));
            assert (!(rsp_keep && out_full && !pop));
            assert (int'(pend_count) + int'(drop)
                    == int'(inflight));
            inflight <= inflight + CW'(issue)
                      - CW'(imem_rsp_valid);
            if (redirect)
                drop <= inflight - CW'(imem_rsp_valid);
            else if (imem_rsp_valid && drop != '0)
                drop <= drop - 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .flush     (redirect),
        .push      (issue),
        .din       (pc_addr),
        .pop       (rsp_keep),
        .dout      (pend_pc),
        .count     (pend_count),
        .full      (pend_full),
        .empty     (pend_empty)
    );

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .flush     (redirect),
        .push      (rsp_keep),
        .din       (out_din),
        .pop       (pop),
        .dout      (out_head),
        .count     (out_count),
        .full      (out_full),
        .empty     (out_empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed phases plus random traffic
// checked against a queue-based model of fetch behaviour.
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk;
    logic        a_reset_n;
    logic [31:0] pc_addr;
    logic        pc_hold;
    logic        redirect;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    instr_fetch #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .DEPTH       (DEPTH)
    ) dut (
        .clk            (clk),
        .a_reset_n      (a_reset_n),
        .pc_addr        (pc_addr),
        .pc_hold        (pc_hold),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit live; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } buf_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    req_t oq[$];
    buf_t bq[$];
    mem_t mq[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    logic [31:0] pc = 0;
    bit          rd = 0;
    logic [31:0] tgt = 0;
    bit          drdy = 1;
    bit          mrdy = 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hFFFF_0000;
    endfunction

    task automatic step();
        bit          rsp;
        bit          ev;
        bit          pp;
        bit          cr;
        bit          iss;
        logic [31:0] rdata;
        req_t        o;
        req_t        nr;
        buf_t        nb;
        mem_t        nm;
        rsp   = (mq.size() > 0) && (mq[0].due <= cyc);
        rdata = rsp ? mem_word(mq[0].addr) : 32'h0;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        redirect       = rd;
        dec_ready      = drdy;
        imem_req_ready = mrdy;
        pc_addr        = pc;
        #1;
        ev  = bq.size() > 0;
        pp  = ev && drdy;
        cr  = (oq.size() + bq.size() - int'(pp)) < DEPTH;
        iss = !rd && cr && mrdy;
        chk("req_valid", {63'h0, imem_req_valid}, {63'h0, !rd && cr});
        chk("pc_hold", {63'h0, pc_hold}, {63'h0, !iss});
        chk("req_addr", {32'h0, imem_req_addr}, {32'h0, pc});
        chk("dec_valid", {63'h0, dec_valid}, {63'h0, ev});
        chk("dec_pc", {32'h0, dec_pc}, {32'h0, ev ? bq[0].pc : 32'h0});
        chk("dec_instr", {32'h0, dec_instr},
            {32'h0, ev ? bq[0].instr : 32'h0});
        @(posedge clk);
        if (pp) void'(bq.pop_front());
        if (rsp) begin
            void'(mq.pop_front());
            if (oq.size() > 0) begin
                o = oq.pop_front();
                if (o.live && !rd) begin
                    nb.pc    = o.pc;
                    nb.instr = rdata;
                    bq.push_back(nb);
                end
            end
        end
        if (rd) begin
            bq.delete();
            foreach (oq[i]) oq[i].live = 0;
        end
        if (iss) begin
            nr.pc   = pc;
            nr.live = 1;
            oq.push_back(nr);
            nm.addr = pc;
            nm.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = nm.due;
            mq.push_back(nm);
        end
        if (rd) pc = tgt;
        else if (iss) pc = pc + 32'd4;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        a_reset_n      = 1'b0;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b1;
        pc_addr        = 32'h0;
        #1;
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("rst_pc_hold", {63'h0, pc_hold}, 64'h1);
        chk("rst_dec_valid", {63'h0, dec_valid}, 64'h0);
        chk("rst_dec_pc", {32'h0, dec_pc}, 64'h0);
        chk("rst_dec_instr", {32'h0, dec_instr}, 64'h0);
        oq.delete();
        bq.delete();
        mq.delete();
        pc = 32'h0;
        rd = 0;
        last_due = cyc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        a_reset_n = 1'b1;
    endtask

    initial begin
        a_reset_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Streaming with a 1-cycle memory.
        lat = 1; drdy = 1; mrdy = 1;
        for (int i = 0; i < 12; i++) step();

        // Decode stalls, then releases.
        drdy = 0;
        for (int i = 0; i < 10; i++) step();
        drdy = 1;
        for (int i = 0; i < 6; i++) step();

        // Redirect with two slow fetches in flight.
        do_reset();
        lat = 3;
        for (int i = 0; i < 20 && pc < 32'h10; i++) step();
        for (int i = 0; i < 20 && oq.size() < 2; i++) step();
        chk("inflight_two", {32'h0, 32'(oq.size())}, 64'd2);
        rd = 1; tgt = 32'h100;
        step();
        rd = 0;
        for (int i = 0; i < 12; i++) step();

        // Redirect coincident with a response and a pop.
        lat = 1;
        begin
            bit hit = 0;
            for (int i = 0; i < 30 && !hit; i++) begin
                if (bq.size() > 0 && mq.size() > 0
                    && mq[0].due <= cyc) hit = 1;
                else step();
            end
            chk("coincident_found", {63'h0, hit}, 64'h1);
        end
        rd = 1; tgt = 32'h200;
        step();
        rd = 0;
        for (int i = 0; i < 8; i++) step();

        // Reset while the buffer is full.
        drdy = 0;
        for (int i = 0; i < 20 && bq.size() < DEPTH; i++) step();
        chk("buf_full", {32'h0, 32'(bq.size())}, DEPTH);
        do_reset();
        drdy = 1;
        for (int i = 0; i < 8; i++) step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rd   = ($urandom_range(0, 15) == 0);
            tgt  = 32'($urandom_range(0, 1023)) << 2;
            drdy = ($urandom_range(0, 3) != 0);
            mrdy = ($urandom_range(0, 4) != 0);
            lat  = $urandom_range(1, 3);
            step();
        end
        rd = 0; drdy = 1; mrdy = 1;
        for (int i = 0; i < 10; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
